// File: rtl/button_debounce_array.sv
// button_debounce_array
//   Array of independent push-button debouncers. Each channel synchronises its
//   raw input, accepts a new level only after it has been stable for
//   STABLE_CYCLES clocks, and emits registered one-cycle press/release pulses.
//
//   Optional feature: define BUTTON_DEBOUNCE_AUTOREPEAT_EN to compile in a
//   per-channel auto-repeat generator driving btn_repeat. Without the macro
//   btn_repeat is tied to zero and no repeat logic exists.
module button_debounce_array #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_status,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  // Stability counter sizing: it only ever reaches STABLE_CYCLES-1.
  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  // Repeat counter sizing covers the longer of the two repeat intervals.
  localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               REP_W     = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_status;
    logic                   r_press;
    logic                   r_release;
    logic                   w_sync;
    logic                   w_differs;
    logic                   w_accept;

    // The last synchroniser stage is the only version of the input used.
    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_differs = w_sync ^ r_status;
    // New level accepted once it has differed for STABLE_CYCLES consecutive edges.
    assign w_accept  = w_differs & (r_cnt == CNT_LAST);

    // Metastability synchroniser chain for the raw button level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {SYNC_STAGES{1'b0}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[g]};
      end
    end

    // Stability counter: runs while input differs, clears on equality or acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (!w_differs || w_accept) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end

    // Debounced level and registered edge pulses, issued on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_status  <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_accept & ~r_status;
        r_release <= w_accept &  r_status;
        if (w_accept) begin
          r_status <= ~r_status;
        end else begin
          r_status <= r_status;
        end
      end
    end

    assign btn_status[g]  = r_status;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_phase;  // 0: waiting for first repeat, 1: periodic
    logic             r_repeat;
    logic [REP_W-1:0] w_rep_last;

    assign w_rep_last = r_rep_phase ? REP_PERIOD_LAST : REP_DELAY_LAST;

    // Auto-repeat timer: idle while released, restarts on every level change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rep_cnt   <= {REP_W{1'b0}};
        r_rep_phase <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (!r_status || w_accept) begin
        r_rep_cnt   <= {REP_W{1'b0}};
        r_rep_phase <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (r_rep_cnt == w_rep_last) begin
        r_rep_cnt   <= {REP_W{1'b0}};
        r_rep_phase <= 1'b1;
        r_repeat    <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + REP_ONE;
        r_rep_phase <= r_rep_phase;
        r_repeat    <= 1'b0;
      end
    end

    assign btn_repeat[g] = r_repeat;
`endif

  end : g_ch

`ifndef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  // Repeat feature not built: output held low.
  assign btn_repeat = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_button_debounce_array.sv
// Self-checking bench for button_debounce_array (CHANNELS=2, STABLE_CYCLES=8,
// SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_PERIOD=5). Works with or without
// BUTTON_DEBOUNCE_AUTOREPEAT_EN defined.
module tb_button_debounce_array;

  localparam int CH     = 2;
  localparam int STABLE = 8;
  localparam int SYNC   = 2;
  localparam int RD     = 20;
  localparam int RP     = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_status;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic [CH-1:0] btn_repeat;

  int n_cmp  = 0;
  int n_bad  = 0;
  int edge_n = 0;
  bit rep_en;

  // Reference model state: pipeline of sampled inputs, accepted level,
  // length of the current run of "differs" edges, and press timestamps.
  logic [SYNC-1:0] m_sync [CH];
  logic            m_status [CH];
  int              m_run [CH];
  logic            m_press [CH];
  logic            m_rel [CH];
  logic            m_rep [CH];
  int              m_press_edge [CH];

  always #5 clk = ~clk;

  button_debounce_array #(
    .CHANNELS(CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_status(btn_status), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_sync[c] = '0; m_status[c] = 1'b0; m_run[c] = 0;
      m_press[c] = 1'b0; m_rel[c] = 1'b0; m_rep[c] = 1'b0; m_press_edge[c] = 0;
    end
  endtask

  // One rising edge of the reference: a level is accepted once the
  // synchronised input has differed from it on STABLE consecutive edges.
  task automatic model_edge(input logic [CH-1:0] in);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int c = 0; c < CH; c++) begin
        logic synced;
        bit   toggle;
        int   k;
        synced = m_sync[c][SYNC-1];
        toggle = 1'b0;
        if (synced != m_status[c]) begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            toggle   = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_press[c] = toggle && !m_status[c];
        m_rel[c]   = toggle &&  m_status[c];
        k = edge_n - m_press_edge[c];
        m_rep[c] = rep_en && m_status[c] && !toggle && (k >= RD) && (((k - RD) % RP) == 0);
        if (toggle) begin
          m_status[c] = !m_status[c];
          if (m_status[c]) m_press_edge[c] = edge_n;
        end
        m_sync[c] = {m_sync[c][SYNC-2:0], in[c]};
      end
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] es, ep, er, et;
    for (int c = 0; c < CH; c++) begin
      es[c] = m_status[c]; ep[c] = m_press[c]; er[c] = m_rel[c]; et[c] = m_rep[c];
    end
    check("model_status",  32'(btn_status),  32'(es));
    check("model_press",   32'(btn_press),   32'(ep));
    check("model_release", 32'(btn_release), 32'(er));
    check("model_repeat",  32'(btn_repeat),  32'(et));
  endtask

  // Drive input, let one rising edge happen, compare on the falling edge.
  task automatic cycle(input logic [CH-1:0] in);
    btn_in = in;
    @(posedge clk);
    edge_n++;
    model_edge(in);
    @(negedge clk);
    compare_model();
  endtask

  // Assert reset mid-cycle and confirm outputs clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_clear();
    check("rst_status",  32'(btn_status),  32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_repeat",  32'(btn_repeat),  32'h0);
  endtask

  initial begin
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    rst_n  = 1'b1;
    btn_in = 2'b11;
    model_clear();
    #1;
    async_reset();
    repeat (3) cycle(2'b11);

    // Release reset with both buttons held: first press must not be suppressed.
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      cycle(2'b11);
      if (j == 9) check("pre_accept_status", 32'(btn_status), 32'h0);
    end
    cycle(2'b11);
    check("post_rst_status_e10", 32'(btn_status), 32'h3);
    check("post_rst_press",      32'(btn_press),  32'h3);
    cycle(2'b11);
    check("post_rst_press_gone", 32'(btn_press),  32'h0);

    // Both released together.
    for (int j = 1; j <= 10; j++) cycle(2'b00);
    check("dual_release", 32'(btn_release), 32'h3);
    repeat (3) cycle(2'b00);

    // Glitch rejection: 7-cycle pulses never accepted.
    for (int r = 0; r < 5; r++) begin
      repeat (7) cycle(2'b01);
      repeat ($urandom_range(2, 5)) cycle(2'b00);
    end
    repeat (10) cycle(2'b00);
    check("glitch_status0", 32'(btn_status[0]), 32'h0);

    // Clean press and release on channel 0 with exact latency.
    for (int j = 1; j <= 9; j++) cycle(2'b01);
    check("ch0_status_e9", 32'(btn_status[0]), 32'h0);
    cycle(2'b01);
    check("ch0_status_e10", 32'(btn_status[0]), 32'h1);
    check("ch0_press_e10",  32'(btn_press[0]),  32'h1);
    cycle(2'b01);
    check("ch0_press_1wide", 32'(btn_press[0]), 32'h0);
    for (int j = 1; j <= 10; j++) cycle(2'b00);
    check("ch0_release", 32'(btn_release[0]), 32'h1);
    check("ch0_rel_status", 32'(btn_status[0]), 32'h0);
    repeat (3) cycle(2'b00);

    // Channel 1 rises on the same edge channel 0 falls.
    repeat (12) cycle(2'b01);
    for (int j = 1; j <= 10; j++) cycle(2'b10);
    check("cross_press1",   32'(btn_press),   32'h2);
    check("cross_release0", 32'(btn_release), 32'h1);

    // Hold channel 1: repeats at press+20, +25, +30 ... when built in.
    for (int j = 1; j <= 60; j++) begin
      cycle(2'b10);
      check("hold_repeat1", 32'(btn_repeat[1]),
            32'(rep_en && (j >= RD) && (((j - RD) % RP) == 0)));
    end
    repeat (14) cycle(2'b00);

    // Reset while channel 0 counter sits at 5: no pulse, restart from zero.
    repeat (7) cycle(2'b01);
    async_reset();
    repeat (2) cycle(2'b01);
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) cycle(2'b01);
    check("rst_mid_no_early", 32'(btn_status[0]), 32'h0);
    cycle(2'b01);
    check("rst_mid_status", 32'(btn_status[0]), 32'h1);
    check("rst_mid_press",  32'(btn_press),     32'h1);

    // Randomised toggling against the model, with one reset in the middle.
    begin
      logic [CH-1:0] cur;
      cur = 2'b01;
      for (int n = 0; n < 600; n++) begin
        for (int b = 0; b < CH; b++)
          if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
        if (n == 300) begin
          async_reset();
          cycle(cur);
          rst_n = 1'b1;
        end
        cycle(cur);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debounce_array.md
BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

Interface
REQ-001 Parameter CHANNELS, default 5, number of independent button channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz, min 1).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth per channel (min 2).
REQ-004 Parameter REPEAT_DELAY, default 50000000, cycles from press to first repeat pulse (min 1).
REQ-005 Parameter REPEAT_PERIOD, default 10000000, cycles between later repeat pulses (min 1).
REQ-006 clk  input  1  single system clock; all flops on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  CHANNELS  raw asynchronous button levels, bit i = channel i.
REQ-009 btn_status  output  CHANNELS  debounced level per channel.
REQ-010 btn_press  output  CHANNELS  one-cycle pulse on debounced 0->1.
REQ-011 btn_release  output  CHANNELS  one-cycle pulse on debounced 1->0.
REQ-012 btn_repeat  output  CHANNELS  one-cycle auto-repeat pulse while held (see Configuration).

Function
REQ-013 Each channel SHALL pass btn_in[i] through SYNC_STAGES flops before any other use; channels share no state.
REQ-014 Each channel SHALL hold a counter of width $clog2(STABLE_CYCLES+1), cleared on any cycle where the synchronised input equals btn_status[i].
REQ-015 The counter SHALL increment on each cycle the synchronised input differs from btn_status[i]; a bounce back to equality before acceptance SHALL clear it (glitch rejected).
REQ-016 On the edge where the counter equals STABLE_CYCLES-1 and the input still differs, btn_status[i] SHALL toggle and the counter SHALL clear.
REQ-017 Latency: a btn_in change held stable from before edge 1 SHALL appear on btn_status at edge SYNC_STAGES+STABLE_CYCLES; a pulse of fewer than STABLE_CYCLES synchronised cycles SHALL never change btn_status.
REQ-018 btn_press[i]/btn_release[i] SHALL be registered, asserted the cycle immediately after the btn_status[i] toggle edge (one cycle wide), never both high in one cycle.
REQ-019 Counters SHALL never wrap; STABLE_CYCLES=1 SHALL make btn_status follow the synchronised input one cycle later.
REQ-020 Simultaneous transitions on several channels SHALL produce simultaneous, independent pulses.

Reset
REQ-021 rst_n low SHALL asynchronously clear all synchroniser flops, counters, btn_status, btn_press, btn_release and btn_repeat to 0.
REQ-022 After rst_n rises with btn_in held 1, the channel SHALL debounce normally and emit one btn_press; no suppression of the first press.
REQ-023 Reset asserted mid-count or mid-repeat SHALL abandon the operation with no pulse emitted.

Configuration
REQ-024 Macro BUTTON_DEBOUNCE_AUTOREPEAT_EN, when defined, SHALL compile in a per-channel repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
REQ-025 With the macro: while btn_status[i]=1, btn_repeat[i] SHALL pulse first REPEAT_DELAY cycles after the btn_press[i] cycle, then every REPEAT_PERIOD cycles; release SHALL stop and clear the counter in the btn_release cycle.
REQ-026 Without the macro: btn_repeat SHALL be constant 0 and no repeat logic SHALL exist; port list unchanged.

Verification (CHANNELS=2, STABLE_CYCLES=8, SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-027 Hold rst_n=0, btn_in=2'b11 -> all outputs 0; release reset -> btn_status=2'b11 at edge 10, btn_press=2'b11 for one cycle after.
REQ-028 btn_in[0] 1 for 7 synchronised cycles then 0, repeated 5 times -> btn_status[0], btn_press[0] stay 0.
REQ-029 btn_in[0] rises and holds -> btn_status[0]=1 at edge 10 exactly, btn_press[0] high one cycle; drop -> btn_status[0]=0 10 edges later, btn_release[0] one cycle.
REQ-030 Channel 1 rises while channel 0 falls on the same edge -> btn_press[1] and btn_release[0] in the same cycle; each channel unaffected by the other.
REQ-031 Macro defined, hold btn_in[1] 60 cycles after acceptance -> btn_repeat[1] pulses at press+20, +25, +30 ... stopping on release; macro undefined -> btn_repeat==0 throughout.
REQ-032 rst_n pulsed low at counter=5 -> all outputs 0 immediately, no press pulse; after release debounce restarts from count 0.
